// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad m:ss BCD entry, per-second countdown, start/stop/door interlock.
// Latency: all outputs registered; a control strobe sampled at edge N is visible right after edge N.
// Backpressure: none; strobes are one-cycle events, and any strobe not legal in the current state is dropped.
module microwave_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       digit_valid_i,
  input  logic [3:0] digit_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       door_open_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_o,
  output logic       running_o,
  output logic       done_o
);

  // The prescaler needs to hold values 0..TICKS_PER_SEC-1.
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sec_ones_q, sec_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      min_q, min_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  // Decoded helpers shared by the next-state logic.
  logic            value_zero;
  logic            digit_ok;
  logic            dec_hits_zero;
  logic [3:0]      dec_ones, dec_tens, dec_min;

  // Condition terms: zero test, digit acceptance, and the one-second borrow chain.
  always_comb begin
    value_zero    = (min_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    // Shifting a units digit above 5 into the tens place would make an illegal
    // seconds value, so such a shift is refused outright.
    digit_ok      = (digit_i <= 4'd9) && (sec_ones_q <= 4'd5);
    // The decrement lands on 0:00 exactly when the current value is 0:01.
    dec_hits_zero = (min_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

    dec_ones = sec_ones_q;
    dec_tens = sec_tens_q;
    dec_min  = min_q;
    if (sec_ones_q != 4'd0) begin
      dec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_q      <= 4'd0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_q      <= min_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update; priority is door_open > stop > start > digit_valid.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_d      = min_q;
    presc_d    = presc_q;

    case (state_q)
      ST_IDLE: begin
        // Stop has nothing to cancel here but still outranks start and digits.
        if (!stop_i) begin
          if (start_i) begin
            // An illegal start (door open or nothing to count) is simply dropped.
            if (!door_open_i && !value_zero) begin
              state_d = ST_RUN;
              presc_d = '0;
            end
          end else if (digit_valid_i && digit_ok) begin
            min_d      = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = digit_i;
          end
        end
      end

      ST_RUN: begin
        if (door_open_i || stop_i) begin
          // Prescaler is left untouched so a resume finishes the partial second.
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_TERM) begin
          presc_d    = '0;
          sec_ones_d = dec_ones;
          sec_tens_d = dec_tens;
          min_d      = dec_min;
          if (dec_hits_zero) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      ST_PAUSE: begin
        // With the door open nothing leaves PAUSE, not even a cancel.
        if (!door_open_i) begin
          if (stop_i) begin
            state_d    = ST_IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_d      = 4'd0;
            presc_d    = '0;
          end else if (start_i) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DONE: begin
        // Any key acknowledges completion; a digit used for this is not entered.
        if (start_i || stop_i || digit_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so the flags register in step with it.
  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  assign sec_ones_o = sec_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign min_o      = min_q;
  assign running_o  = running_q;
  assign done_o     = done_q;

endmodule
